// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the EX-stage iterative divider.
//   - DIV_OP_* : bit positions inside the one-hot div_op vector
//   - div_state_e : sequencing FSM states
//   - DIV_ITER / DIV_CNT_W : iteration count and step counter width
//   - div_cond_neg : conditional two's-complement negate
// No ports (package).
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 5;

  localparam int DIV_OP_DIV  = 3;
  localparam int DIV_OP_DIVU = 2;
  localparam int DIV_OP_REM  = 1;
  localparam int DIV_OP_REMU = 0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_XLEN-1:0] div_cond_neg(input logic [DIV_XLEN-1:0] v,
                                                       input logic              neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// One restoring shift-subtract step per cycle on a 64-bit {rem, quo} register.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : load {0, a_mag} and clear the partial remainder
//   step        : perform one division step
//   a_mag       : dividend magnitude
//   b_mag       : divisor magnitude (held stable by the controller)
//   quo_mag     : quotient magnitude after 32 steps
//   rem_mag     : remainder magnitude after 32 steps
// -----------------------------------------------------------------------------
module div_iter
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step,
  input  logic [DIV_XLEN-1:0] a_mag,
  input  logic [DIV_XLEN-1:0] b_mag,
  output logic [DIV_XLEN-1:0] quo_mag,
  output logic [DIV_XLEN-1:0] rem_mag
);

  logic [2*DIV_XLEN-1:0] acc_q;
  logic [DIV_XLEN:0]     rem_sh;
  logic [DIV_XLEN:0]     sub;
  logic                  borrow;

  // The shifted remainder can reach 33 bits when |b| is above 2^31. A 33-bit
  // subtract of the low 32 bits plus the shifted-out top bit gives the true
  // borrow: the trial only fails when the top bit is clear and the low part
  // underflows. On success the true difference is below |b|, so 32 bits hold it.
  always_comb begin
    rem_sh = acc_q[2*DIV_XLEN-1:DIV_XLEN-1];
    sub    = {1'b0, rem_sh[DIV_XLEN-1:0]} - {1'b0, b_mag};
    borrow = ~rem_sh[DIV_XLEN] & sub[DIV_XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (start) begin
      acc_q <= {{DIV_XLEN{1'b0}}, a_mag};
    end else if (step) begin
      acc_q <= {(borrow ? rem_sh[DIV_XLEN-1:0] : sub[DIV_XLEN-1:0]),
                acc_q[DIV_XLEN-2:0], ~borrow};
    end
  end

  assign quo_mag = acc_q[DIV_XLEN-1:0];
  assign rem_mag = acc_q[2*DIV_XLEN-1:DIV_XLEN];

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequencing controller for the EX-stage iterative divider (RV32M DIV, DIVU,
// REM, REMU). Runs a 32-step restoring division on operand magnitudes, fixes
// signs, applies the divide-by-zero and signed-overflow results, stalls the
// front of the pipeline while busy, holds the result under downstream stall
// and aborts on a branch flush.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   div_op     : one-hot {DIV, DIVU, REM, REMU}, all-zero = no divide
//   a, b       : dividend (rs1) and divisor (rs2)
//   hold       : EX instruction cannot advance this cycle
//   flush      : branch flush of the EX slot
//   stallreq   : EX busy, freeze IF/ID/EX
//   result     : quotient or remainder, 0 unless res_valid
//   res_valid  : result ready this cycle
// Build option:
//   DIV_FASTPATH_EN : divide-by-zero and signed overflow skip BUSY and
//                     reach DONE one cycle after acceptance.
// -----------------------------------------------------------------------------
module div_ctrl
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          div_op,
  input  logic [DIV_XLEN-1:0] a,
  input  logic [DIV_XLEN-1:0] b,
  input  logic                hold,
  input  logic                flush,
  output logic                stallreq,
  output logic [DIV_XLEN-1:0] result,
  output logic                res_valid
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [3:0]           op_q;
  logic                 sa_q, sb_q;
  logic                 bz_q, ovf_q;
  logic [DIV_XLEN-1:0]  a_raw_q, a_mag_q, b_mag_q;

  logic                 start, step;
  logic                 op_valid, op_signed_in, a_neg_in, b_neg_in;
  logic                 bz_in, ovf_in;
  logic [DIV_XLEN-1:0]  quo_mag, rem_mag;
  logic [DIV_XLEN-1:0]  quo_fix, rem_fix;
  logic                 is_div, is_rem;

  always_comb begin
    op_valid     = |div_op;
    op_signed_in = div_op[DIV_OP_DIV] | div_op[DIV_OP_REM];
    a_neg_in     = op_signed_in & a[DIV_XLEN-1];
    b_neg_in     = op_signed_in & b[DIV_XLEN-1];
    bz_in        = (b == '0);
    ovf_in       = op_signed_in & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides everything: back to IDLE, no stall, no new op accepted.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    step      = 1'b0;
    stallreq  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (op_valid) begin
          start    = 1'b1;
          stallreq = 1'b1;
`ifdef DIV_FASTPATH_EN
          state_d  = (bz_in | ovf_in) ? DIV_DONE : DIV_BUSY;
`else
          state_d  = DIV_BUSY;
`endif
        end
      end
      DIV_BUSY: begin
        step     = 1'b1;
        stallreq = 1'b1;
        if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        res_valid = 1'b1;
        if (!hold) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
    if (flush) begin
      state_d  = DIV_IDLE;
      start    = 1'b0;
      step     = 1'b0;
      stallreq = 1'b0;
    end
  end

  // Operation context captured at acceptance; the counter wraps 31 -> 0 on
  // the final step so it is already clear for the next op.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      a_raw_q <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
    end else begin
      if (start) begin
        cnt_q   <= '0;
        op_q    <= div_op;
        sa_q    <= a_neg_in;
        sb_q    <= b_neg_in;
        bz_q    <= bz_in;
        ovf_q   <= ovf_in;
        a_raw_q <= a;
        a_mag_q <= div_cond_neg(a, a_neg_in);
        b_mag_q <= div_cond_neg(b, b_neg_in);
      end
      if (step) begin
        cnt_q <= cnt_q + DIV_CNT_W'(1);
      end
    end
  end

  div_iter u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .step    (step),
    .a_mag   (div_cond_neg(a, a_neg_in)),
    .b_mag   (b_mag_q),
    .quo_mag (quo_mag),
    .rem_mag (rem_mag)
  );

  // Special cases take precedence over the iterated magnitudes; the fast
  // path never runs the iterator, so these must not depend on it.
  always_comb begin
    is_div  = op_q[DIV_OP_DIV] | op_q[DIV_OP_DIVU];
    is_rem  = op_q[DIV_OP_REM] | op_q[DIV_OP_REMU];
    quo_fix = div_cond_neg(quo_mag, sa_q ^ sb_q);
    rem_fix = div_cond_neg(rem_mag, sa_q);
    result  = '0;
    if (state_q == DIV_DONE) begin
      if (bz_q) begin
        result = is_rem ? a_raw_q : 32'hFFFF_FFFF;
      end else if (ovf_q) begin
        result = is_rem ? 32'h0000_0000 : 32'h8000_0000;
      end else if (is_rem) begin
        result = rem_fix;
      end else if (is_div) begin
        result = quo_fix;
      end
    end
  end

  // a_mag_q is kept for debug visibility of the captured dividend magnitude.
  logic unused_a_mag;
  assign unused_a_mag = ^a_mag_q;

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl: table of directed divide vectors with
// hand-computed results and latencies, plus sequences for flush mid-BUSY,
// hold in DONE and reset mid-BUSY. Honours DIV_FASTPATH_EN for latencies.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0010;
  localparam logic [3:0] OP_REMU = 4'b0001;

  logic        clk;
  logic        rst_n;
  logic [3:0]  div_op;
  logic [31:0] a, b;
  logic        hold, flush;
  logic        stallreq;
  logic [31:0] result;
  logic        res_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[18];

  div_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_op    (div_op),
    .a         (a),
    .b         (b),
    .hold      (hold),
    .flush     (flush),
    .stallreq  (stallreq),
    .result    (result),
    .res_valid (res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int expLatency(input bit special);
`ifdef DIV_FASTPATH_EN
    return special ? 1 : 33;
`else
    if (special) return 33;
    return 33;
`endif
  endfunction

  // Drives an op at a falling edge (cycle 0) and waits for res_valid, counting
  // cycles and stallreq-high cycles. Returns #1 after the falling edge of the
  // DONE cycle with div_op still applied.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                               output int lat, output int stalls, output logic [31:0] res);
    @(negedge clk);
    div_op = op;
    a      = av;
    b      = bv;
    #1;
    lat    = 0;
    stalls = 0;
    while (!res_valid && lat < 100) begin
      if (stallreq) stalls++;
      @(negedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  initial begin
    int          lat, stalls;
    logic [31:0] res;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          1'b1};
    vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b1};
    vecs[8]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0};
    vecs[9]  = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    vecs[10] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[11] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          1'b0};
    vecs[13] = '{OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  1'b0};
    vecs[14] = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[15] = '{OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          1'b0};
    vecs[16] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0};
    vecs[17] = '{OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0};

    rst_n  = 1'b0;
    div_op = 4'b0;
    a      = '0;
    b      = '0;
    hold   = 1'b0;
    flush  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_stallreq",  32'(stallreq),  32'd0);
    checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_result",    result,         32'd0);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, stalls, res);
      checkOutput($sformatf("vec%0d_result", i),    res,        vecs[i].exp);
      checkOutput($sformatf("vec%0d_res_valid", i), 32'(res_valid), 32'd1);
      checkOutput($sformatf("vec%0d_latency", i),   32'(lat),   32'(expLatency(vecs[i].special)));
      checkOutput($sformatf("vec%0d_stalls", i),    32'(stalls), 32'(expLatency(vecs[i].special)));
      checkOutput($sformatf("vec%0d_done_stall", i), 32'(stallreq), 32'd0);
      div_op = 4'b0;
    end

    $display("[TB] flush mid-BUSY");
    @(negedge clk);
    div_op = OP_DIVU;
    a      = 32'd9;
    b      = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("flush_pre_stall", 32'(stallreq), 32'd1);
    flush  = 1'b1;
    div_op = 4'b0;
    #1;
    checkOutput("flush_comb_stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_idle_stall", 32'(stallreq),  32'd0);
    checkOutput("flush_idle_valid", 32'(res_valid), 32'd0);
    applyStimulus(OP_DIVU, 32'd9, 32'd3, lat, stalls, res);
    checkOutput("after_flush_result",  res,      32'd3);
    checkOutput("after_flush_latency", 32'(lat), 32'd33);
    div_op = 4'b0;

    $display("[TB] hold in DONE");
    applyStimulus(OP_DIVU, 32'd100, 32'd7, lat, stalls, res);
    checkOutput("hold_first_result", res, 32'd14);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("hold%0d_valid", k),  32'(res_valid), 32'd1);
      checkOutput($sformatf("hold%0d_result", k), result,         32'd14);
      checkOutput($sformatf("hold%0d_stall", k),  32'(stallreq),  32'd0);
    end
    hold   = 1'b0;
    div_op = 4'b0;
    @(negedge clk);
    #1;
    checkOutput("hold_release_valid",  32'(res_valid), 32'd0);
    checkOutput("hold_release_result", result,         32'd0);
    checkOutput("hold_release_stall",  32'(stallreq),  32'd0);

    $display("[TB] reset mid-BUSY");
    @(negedge clk);
    div_op = OP_DIVU;
    a      = 32'd100;
    b      = 32'd7;
    repeat (6) @(negedge clk);
    rst_n  = 1'b0;
    div_op = 4'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_busy_stall",  32'(stallreq),  32'd0);
    checkOutput("rst_busy_valid",  32'(res_valid), 32'd0);
    checkOutput("rst_busy_result", result,         32'd0);
    rst_n = 1'b1;
    applyStimulus(OP_REMU, 32'd100, 32'd7, lat, stalls, res);
    checkOutput("after_rst_result",  res,      32'd2);
    checkOutput("after_rst_latency", 32'(lat), 32'd33);
    div_op = 4'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the EX-stage iterative divider. It accepts a one-hot divide op with two 32-bit operands and runs a 32-step restoring division on magnitudes. It applies RV32M sign and special-case rules and raises `stallreq` to freeze the front of the pipeline until the result is ready. It holds the finished result while downstream stages stall, and aborts cleanly on a branch flush.

## Interface
- Parameters: none. Word width is fixed at 32. Iteration count comes from the shared package.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; synchronous, active-low
- `div_op`  in  4  one-hot {DIV, DIVU, REM, REMU}, bit 3 = DIV; all-zero = no divide
- `a`  in  32  dividend (rs1); stable while `stallreq`=1
- `b`  in  32  divisor (rs2); stable while `stallreq`=1
- `hold`  in  1  downstream stall: EX instruction cannot advance this cycle
- `flush`  in  1  branch flush of the EX slot
- `stallreq`  out  1  EX busy; freeze IF/ID/EX
- `result`  out  32  quotient or remainder; valid when `res_valid`=1
- `res_valid`  out  1  result ready this cycle

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE, counter 0, all registers 0.
- IDLE:
  - If `div_op`≠0 and `flush`=0: latch the operation, the signs (signed ops only), |a|, and |b|; clear the partial remainder.
  - Go to BUSY. With the fast-path feature, go to DONE instead when the operation is special.
- BUSY:
  - Each cycle: shift the remainder/dividend left 1 bit; trial-subtract |b| (33-bit subtract); set the quotient bit to ¬borrow; increment the counter.
  - After step 32 (counter 31 → wrap): go to DONE.
- DONE:
  - `res_valid`=1 and `result` is driven from registered values.
  - If `hold`=1, stay in DONE with `result` stable. No restart, even though `div_op` is still present.
  - If `hold`=0, go to IDLE next cycle.
- `flush` in any state: go to IDLE next cycle, clear the counter, and discard partial state. `flush` takes priority over `hold` and over a new op.
- Sign fix: quotient negated iff signed and sa≠sb; remainder negated iff signed and sa=1.
- Special cases (RV32M), applied in the DONE output mux:
  - b=0: quotient = 0xFFFF_FFFF; remainder = a.
  - Signed a=0x8000_0000, b=0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
- Combinational outputs:
  - `stallreq` = ¬flush ∧ ((IDLE ∧ div_op≠0) ∨ BUSY).
  - `res_valid` = DONE.
  - `result` = 0 outside DONE.
- Reset values: `stallreq`=0, `res_valid`=0, `result`=0.

## Timing
- Cycle 0 (IDLE, op present): `stallreq`=1 combinationally; operands are captured.
- Cycles 1–32: BUSY, `stallreq`=1.
- Cycle 33: DONE, `stallreq`=0, `res_valid`=1. The instruction leaves EX at the end of cycle 33 if `hold`=0.
- Normal op: `stallreq` high for exactly 33 cycles.
- Fast path (feature on): DONE at cycle 1, `stallreq` high for 1 cycle.
- Back-to-back divides: the next op is accepted in IDLE at cycle 34 at the earliest.
- Reset asserted mid-BUSY: IDLE next cycle, outputs 0.

## Configuration
- `DIV_FASTPATH_EN` defined:
  - Divide-by-zero and signed overflow are detected in IDLE, skip BUSY, and reach DONE in cycle 1.
  - Same result values as without the feature.
- Not defined: every op takes the full 32-step path. Special-case results still come from the DONE mux.

## Structure
- Shared package `div_pkg`:
  - `DIV_OP_*` one-hot bit indices
  - FSM state enum
  - `DIV_ITER` = 32
  - counter width 5
- Sub-module `div_iter`: one restoring shift-subtract step per cycle on a 64-bit {rem, quo} register.
  - Ports: `start`, `step`, `|a|`, `|b|`.
  - Outputs: quotient and remainder magnitudes.
- `div_ctrl` owns the FSM, counter, sign handling, special cases, and the stall/hold/flush logic.

## Test plan
- DIVU a=100, b=7 → `stallreq` high 33 cycles; cycle 33 `result`=14, `res_valid`=1. REMU on the same operands → 2.
- DIV a=−7 (0xFFFF_FFF9), b=2 → 0xFFFF_FFFD (−3). REM on the same operands → 0xFFFF_FFFF (−1).
- DIV a=5, b=0 → 0xFFFF_FFFF; REM a=5, b=0 → 5. With `DIV_FASTPATH_EN`: `res_valid` at cycle 1. Without it: cycle 33.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000; REM on the same operands → 0.
- `flush` at cycle 10 of BUSY → cycle 11 IDLE, `stallreq`=0; a fresh DIVU 9/3 then returns 3 after the full latency.
- `hold`=1 for 5 cycles in DONE → `result` stable, no restart; `hold`=0 → IDLE next cycle, `res_valid`=0.
